// File: rtl/word_serial_tx_pkg.sv
// Shared types and framing constants for the word-serial transmitter.
package word_serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int FRAME_SYNC_BITS = 8;
  localparam int FRAME_DATA_BITS = 32;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/word_serial_tx_if.sv
// Word handshake between a producer and the word-serial transmitter.
interface word_serial_tx_if;
  import word_serial_tx_pkg::*;

  logic [FRAME_DATA_BITS-1:0] word_in;
  logic                       word_valid;
  logic                       word_ready;

  modport master (output word_in, output word_valid, input  word_ready);
  modport slave  (input  word_in, input  word_valid, output word_ready);
endinterface

// File: rtl/word_serial_tx.sv
// Serialises 32-bit words as SYNC_BYTE + word (MSB first) + even parity,
// followed by GAP_CYCLES idle bit-times.
module word_serial_tx
  import word_serial_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int         GAP_CYCLES = 4
) (
  input  logic                t_clk,
  input  logic                rst_n,
  word_serial_tx_if.slave     word_if,
  output logic                data_out,
  output logic                tx_busy,
  output logic                frame_done,
  output logic [15:0]         frame_cnt
);

  // Six bits cover the 33 DATA bit-times; widened only when the gap needs it.
  localparam int CNT_W = (GAP_CYCLES > 63) ? 8 : 6;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST_SYNC = cnt_t'(FRAME_SYNC_BITS - 1);
  localparam cnt_t LAST_DATA = cnt_t'(FRAME_DATA_BITS - 1);
  localparam cnt_t GAP_LAST  = cnt_t'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e                     state_q, state_d;
  cnt_t                       cnt_q, cnt_d;
  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic                       parity_q, parity_d;
  logic                       data_out_q, data_out_d;
  logic                       frame_done_q, frame_done_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic                       run_q;
  logic                       handshake;
  logic [2:0]                 sync_idx;

  assign word_if.word_ready = run_q && (state_q == IDLE);
  assign handshake          = word_if.word_valid && word_if.word_ready;
  assign sync_idx           = 3'(FRAME_SYNC_BITS - 2) - cnt_q[2:0];

  assign data_out   = data_out_q;
  assign tx_busy    = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  // data_out_d is the bit that will be on the line for the next bit-time.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    data_out_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d    = SYNC;
          cnt_d      = '0;
          shift_d    = word_if.word_in;
          data_out_d = SYNC_BYTE[7];
        end
      end
      SYNC: begin
        if (cnt_q == LAST_SYNC) begin
          state_d    = DATA;
          cnt_d      = '0;
          data_out_d = shift_q[FRAME_DATA_BITS-1];
          parity_d   = shift_q[FRAME_DATA_BITS-1];
          shift_d    = {shift_q[FRAME_DATA_BITS-2:0], 1'b0};
        end else begin
          cnt_d      = cnt_q + 1'b1;
          data_out_d = SYNC_BYTE[sync_idx];
        end
      end
      DATA: begin
        if (cnt_q < LAST_DATA) begin
          cnt_d      = cnt_q + 1'b1;
          data_out_d = shift_q[FRAME_DATA_BITS-1];
          parity_d   = parity_q ^ shift_q[FRAME_DATA_BITS-1];
          shift_d    = {shift_q[FRAME_DATA_BITS-2:0], 1'b0};
        end else if (cnt_q == LAST_DATA) begin
          cnt_d        = cnt_q + 1'b1;
          data_out_d   = parity_q;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end else begin
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      data_out_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      run_q        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_word_serial_tx.sv
// Directed self-checking bench for word_serial_tx (GAP_CYCLES=4 and 0 instances).
module tb_word_serial_tx;
  import word_serial_tx_pkg::*;

  logic t_clk = 1'b0;
  logic rst_n;
  always #5 t_clk = ~t_clk;

  word_serial_tx_if if4 ();
  word_serial_tx_if if0 ();

  logic        dout4, busy4, done4, dout0, busy0, done0;
  logic [15:0] cnt4, cnt0;

  word_serial_tx #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(4)) u_dut4 (
    .t_clk(t_clk), .rst_n(rst_n), .word_if(if4),
    .data_out(dout4), .tx_busy(busy4), .frame_done(done4), .frame_cnt(cnt4)
  );

  word_serial_tx #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(0)) u_dut0 (
    .t_clk(t_clk), .rst_n(rst_n), .word_if(if0),
    .data_out(dout0), .tx_busy(busy0), .frame_done(done0), .frame_cnt(cnt0)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic f_dout(input int sel);
    return (sel == 4) ? dout4 : dout0;
  endfunction
  function automatic logic f_busy(input int sel);
    return (sel == 4) ? busy4 : busy0;
  endfunction
  function automatic logic f_done(input int sel);
    return (sel == 4) ? done4 : done0;
  endfunction
  function automatic logic f_rdy(input int sel);
    return (sel == 4) ? if4.word_ready : if0.word_ready;
  endfunction
  function automatic logic [15:0] f_cnt(input int sel);
    return (sel == 4) ? cnt4 : cnt0;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [31:0] w);
    if (sel == 4) begin
      if4.word_valid = v;
      if4.word_in    = w;
    end else begin
      if0.word_valid = v;
      if0.word_in    = w;
    end
  endtask

  // Waits (bounded) for ready, presents the word and returns just after the accepting edge.
  task automatic handshake(input int sel, input logic [31:0] w);
    int n;
    n = 0;
    @(negedge t_clk);
    while (!f_rdy(sel) && n < 100) begin
      @(negedge t_clk);
      n++;
    end
    checks++;
    if (f_rdy(sel) !== 1'b1) begin
      errors++;
      $display("FAIL handshake_wait dut%0d word_ready=%b required=1", sel, f_rdy(sel));
    end
    set_in(sel, 1'b1, w);
    @(posedge t_clk);
  endtask

  // mode 0: drop valid; mode 1: scramble word_in/word_valid; mode 2: queue 0x9ABCDEF0 behind.
  task automatic capture(input int sel, input int n, input int mode,
                         output logic [127:0] bits, output int dcnt, output int dpos,
                         output logic [15:0] cnt_at_done, output logic [15:0] cnt_before,
                         output int rdy_hi);
    bits = '0; dcnt = 0; dpos = -1; cnt_at_done = '0; cnt_before = '0; rdy_hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge t_clk);
      case (mode)
        0: if (i == 0) set_in(sel, 1'b0, 32'h0);
        1: if (i < n - 1) set_in(sel, 1'($urandom), $urandom);
           else set_in(sel, 1'b0, 32'h0);
        default: if (i == 0) set_in(sel, 1'b1, 32'h9ABC_DEF0);
                 else if (i == 50) set_in(sel, 1'b0, 32'h0);
      endcase
      bits[n-1-i] = f_dout(sel);
      if (f_done(sel) === 1'b1) begin
        dcnt++;
        dpos = i;
        cnt_at_done = f_cnt(sel);
      end
      if (i == n - 2) cnt_before = f_cnt(sel);
      if (f_rdy(sel) === 1'b1) rdy_hi++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({dout4, busy4, done4, if4.word_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs4 got=%b required=0000", {dout4, busy4, done4, if4.word_ready});
    end
    checks++;
    if (cnt4 !== 16'h0000 || cnt0 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_frame_cnt got=%h/%h required=0000/0000", cnt4, cnt0);
    end
    checks++;
    if ({dout0, busy0, done0, if0.word_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs0 got=%b required=0000", {dout0, busy0, done0, if0.word_ready});
    end
    @(negedge t_clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (if4.word_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got=%b required=0", if4.word_ready);
    end
    @(negedge t_clk);
    checks++;
    if (if4.word_ready !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_edge got=%b%b required=10", if4.word_ready, busy4);
    end
  endtask

  task automatic test_word_one();
    logic [127:0] b; int dc, dp, rh; logic [15:0] cd, cb;
    handshake(4, 32'h0000_0001);
    capture(4, 41, 0, b, dc, dp, cd, cb, rh);
    checks++;
    if (b[40:0] !== {8'b1010_0101, 31'h0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL word_one_bits got=%h required=%h", b[40:0], {8'b1010_0101, 31'h0, 1'b1, 1'b1});
    end
    checks++;
    if (dc !== 1 || dp !== 40) begin
      errors++;
      $display("FAIL word_one_done got=%0d@%0d required=1@40", dc, dp);
    end
    checks++;
    if (cb !== 16'd0 || cd !== 16'd1) begin
      errors++;
      $display("FAIL word_one_cnt got=%0d->%0d required=0->1", cb, cd);
    end
  endtask

  task automatic test_all_ones();
    logic [127:0] b; int dc, dp, rh, low; logic [15:0] cd, cb;
    handshake(4, 32'hFFFF_FFFF);
    capture(4, 41, 0, b, dc, dp, cd, cb, rh);
    checks++;
    if (b[40:0] !== {8'hA5, 32'hFFFF_FFFF, 1'b0}) begin
      errors++;
      $display("FAIL all_ones_bits got=%h required=%h", b[40:0], {8'hA5, 32'hFFFF_FFFF, 1'b0});
    end
    low = 41 - rh;
    @(negedge t_clk);
    checks++;
    if (dout4 !== 1'b0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL gap_line got=dout%b busy%b required=dout0 busy1", dout4, busy4);
    end
    for (int i = 0; i < 20 && if4.word_ready !== 1'b1; i++) begin
      low++;
      @(negedge t_clk);
    end
    checks++;
    if (low !== 45 || if4.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_low_span got=%0d required=45", low);
    end
    checks++;
    if (cnt4 !== 16'd2) begin
      errors++;
      $display("FAIL all_ones_cnt got=%0d required=2", cnt4);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] b; int dc, dp, rh; logic [15:0] cd, cb;
    logic [82:0] exp;
    exp = {8'hA5, 32'h1234_5678, 1'b1, 1'b0, 8'hA5, 32'h9ABC_DEF0, 1'b1};
    handshake(0, 32'h1234_5678);
    capture(0, 83, 2, b, dc, dp, cd, cb, rh);
    checks++;
    if (b[82:0] !== exp) begin
      errors++;
      $display("FAIL back_to_back_bits got=%h required=%h", b[82:0], exp);
    end
    checks++;
    if (dc !== 2 || cnt0 !== 16'd2) begin
      errors++;
      $display("FAIL back_to_back_cnt got=%0d pulses cnt=%0d required=2 pulses cnt=2", dc, cnt0);
    end
  endtask

  task automatic test_toggle();
    logic [127:0] b; int dc, dp, rh; logic [15:0] cd, cb;
    handshake(4, 32'hC3A5_0F96);
    capture(4, 41, 1, b, dc, dp, cd, cb, rh);
    checks++;
    if (b[40:0] !== {8'hA5, 32'hC3A5_0F96, 1'b0}) begin
      errors++;
      $display("FAIL toggle_bits got=%h required=%h", b[40:0], {8'hA5, 32'hC3A5_0F96, 1'b0});
    end
    checks++;
    if (cnt4 !== 16'd3) begin
      errors++;
      $display("FAIL toggle_cnt got=%0d required=3", cnt4);
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] b; int dc, dp, rh; logic [15:0] cd, cb;
    handshake(4, 32'hDEAD_BEEF);
    capture(4, 21, 0, b, dc, dp, cd, cb, rh);
    checks++;
    if (dout4 !== 1'b1 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort_line got=dout%b busy%b required=dout1 busy1", dout4, busy4);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dout4, busy4, done4, if4.word_ready} !== 4'b0000 || cnt4 !== 16'd0) begin
      errors++;
      $display("FAIL abort_async got=%b cnt=%0d required=0000 cnt=0",
               {dout4, busy4, done4, if4.word_ready}, cnt4);
    end
    dc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge t_clk);
      if (done4 === 1'b1 || busy4 === 1'b1) dc++;
    end
    checks++;
    if (dc !== 0) begin
      errors++;
      $display("FAIL abort_quiet got=%0d active cycles required=0", dc);
    end
    rst_n = 1'b1;
    @(negedge t_clk);
    checks++;
    if (if4.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_abort got=%b required=1", if4.word_ready);
    end
    handshake(4, 32'h0F0F_5555);
    capture(4, 41, 0, b, dc, dp, cd, cb, rh);
    checks++;
    if (b[40:0] !== {8'hA5, 32'h0F0F_5555, 1'b0} || cd !== 16'd1) begin
      errors++;
      $display("FAIL post_abort_frame got=%h cnt=%0d required=%h cnt=1",
               b[40:0], cd, {8'hA5, 32'h0F0F_5555, 1'b0});
    end
  endtask

  task automatic test_wrap();
    logic [127:0] b; int dc, dp, rh; logic [15:0] cd, cb;
    for (int i = 0; i < 20 && if4.word_ready !== 1'b1; i++) @(negedge t_clk);
    force u_dut4.frame_cnt_q = 16'hFFFF;
    @(negedge t_clk);
    release u_dut4.frame_cnt_q;
    #1;
    checks++;
    if (cnt4 !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload got=%h required=ffff", cnt4);
    end
    handshake(4, 32'h8000_0000);
    capture(4, 41, 0, b, dc, dp, cd, cb, rh);
    checks++;
    if (cb !== 16'hFFFF || cd !== 16'h0000 || dc !== 1) begin
      errors++;
      $display("FAIL wrap_cnt got=%h->%h pulses=%0d required=ffff->0000 pulses=1", cb, cd, dc);
    end
    checks++;
    if (b[40:0] !== {8'hA5, 32'h8000_0000, 1'b1}) begin
      errors++;
      $display("FAIL wrap_bits got=%h required=%h", b[40:0], {8'hA5, 32'h8000_0000, 1'b1});
    end
  endtask

  initial begin
    set_in(4, 1'b0, 32'h0);
    set_in(0, 1'b0, 32'h0);
    test_reset();
    test_word_one();
    test_all_ones();
    test_back_to_back();
    test_toggle();
    test_mid_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
